// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and limits for the unified memory port arbiter.
// Imported by the arbiter top and its winner-selection sub-module.
package rv_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 4;
  localparam int MAX_STREAK_MIN = 1;
  localparam int MAX_STREAK_MAX = 15;

  localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

  // The memory is word-addressed; byte-offset bits never leave the arbiter.
  function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr & WORD_ADDR_MASK;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and memory-port signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_port_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_be, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_be, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection between fetch and load/store, with the anti-starvation
// streak counter that bounds consecutive data grants while fetch waits.
module mem_arb_pick
  import rv_mem_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_req,
  input  logic arb_en,
  output logic pick_if,
  output logic pick_ls
);

  localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

  logic [3:0] streak_reg;
  logic       if_starved;

  assign if_starved = if_req && (streak_reg == STREAK_LIMIT);
  assign pick_ls    = arb_en && ls_req && !if_starved;
  assign pick_if    = arb_en && if_req && !pick_ls;

  // Only data grants that actually make fetch wait count toward the streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_reg <= '0;
    end else if (!if_req || pick_if) begin
      streak_reg <= '0;
    end else if (pick_ls && (streak_reg < STREAK_LIMIT)) begin
      streak_reg <= streak_reg + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous unified memory port between instruction fetch and
// the load/store unit; one transaction in flight, data has priority.
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT = (MEM_LAT < MEM_LAT_MIN) ? MEM_LAT_MIN :
                       (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;
  localparam int STREAK = (MAX_STREAK < MAX_STREAK_MIN) ? MAX_STREAK_MIN :
                          (MAX_STREAK > MAX_STREAK_MAX) ? MAX_STREAK_MAX : MAX_STREAK;

  arb_state_t state_reg;
  owner_t     owner_reg;
  logic       we_reg;
  logic [2:0] lat_cnt_reg;

  logic rsp_cycle;
  logic arb_en;
  logic pick_if;
  logic pick_ls;
  logic granted;

  assign rsp_cycle = (state_reg == WAIT) && (lat_cnt_reg == 3'd1);
  // Gating with rst keeps grants off combinationally while reset is held.
  assign arb_en    = !rst && ((state_reg == IDLE) || rsp_cycle);
  assign granted   = pick_if || pick_ls;

  mem_arb_pick #(
    .MAX_STREAK (STREAK)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .if_req  (bus.if_req),
    .ls_req  (bus.ls_req),
    .arb_en  (arb_en),
    .pick_if (pick_if),
    .pick_ls (pick_ls)
  );

  always_comb begin
    bus.if_gnt    = pick_if;
    bus.ls_gnt    = pick_ls;
    bus.mem_en    = granted;
    bus.mem_we    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (pick_ls) begin
      bus.mem_addr  = word_addr(bus.ls_addr);
      bus.mem_we    = bus.ls_we ? bus.ls_be : 4'b0000;
      bus.mem_wdata = bus.ls_wdata;
    end else if (pick_if) begin
      bus.mem_addr  = word_addr(bus.if_addr);
      bus.mem_wdata = bus.ls_wdata;
    end
  end

  // Store responses carry no data, so their rdata is forced quiet.
  always_comb begin
    bus.if_rvalid = rsp_cycle && (owner_reg == OWN_IF);
    bus.ls_rvalid = rsp_cycle && (owner_reg == OWN_LS);
    bus.if_rdata  = bus.mem_rdata;
    bus.ls_rdata  = (rsp_cycle && we_reg) ? 32'h0 : bus.mem_rdata;
  end

  // A grant on the response cycle chains the next access without an idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      owner_reg   <= OWN_IF;
      we_reg      <= 1'b0;
      lat_cnt_reg <= '0;
    end else if (granted) begin
      state_reg   <= WAIT;
      owner_reg   <= pick_ls ? OWN_LS : OWN_IF;
      we_reg      <= pick_ls && bus.ls_we;
      lat_cnt_reg <= 3'(LAT);
    end else if (state_reg == WAIT) begin
      if (rsp_cycle) begin
        state_reg   <= IDLE;
        lat_cnt_reg <= '0;
      end else begin
        lat_cnt_reg <= lat_cnt_reg - 3'd1;
      end
    end
  end

endmodule
